// File: rtl/ro_pair_measure.sv
// Ring-oscillator pair measurement controller: clears, gates and compares one RO pair at a time.
// Latency: RESP_BITS*(W+4)+1 cycles from the accepted start edge to the resp_valid pulse.
// Backpressure: none; start is sampled only in IDLE, and a start while busy is dropped.
module ro_pair_measure #(
  parameter int CNT_SIZE  = 32,
  parameter int WIN_SIZE  = 16,
  parameter int RESP_BITS = 8,
  localparam int SEL_W    = $clog2(RESP_BITS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIN_SIZE-1:0]  window,
  input  logic [CNT_SIZE-1:0]  cnt_a,
  input  logic [CNT_SIZE-1:0]  cnt_b,
  output logic                 cnt_en,
  output logic                 cnt_clr,
  output logic [SEL_W-1:0]     pair_sel,
  output logic                 busy,
  output logic                 resp_valid,
  output logic [RESP_BITS-1:0] response,
  output logic [RESP_BITS-1:0] tie_mask
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_COUNT   = 3'd2,
    S_SETTLE  = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [WIN_SIZE-1:0]  win_m1_q, win_m1_d;   // window length minus one, 0 and 1 both map to 0
  logic [WIN_SIZE-1:0]  timer_q, timer_d;
  logic                 settle_q, settle_d;   // second settle cycle marker
  logic [SEL_W-1:0]     pair_sel_q, pair_sel_d;
  logic [RESP_BITS-1:0] sh_resp_q, sh_resp_d;
  logic [RESP_BITS-1:0] sh_tie_q, sh_tie_d;

  logic                 cnt_en_q, cnt_en_d;
  logic                 cnt_clr_q, cnt_clr_d;
  logic                 busy_q, busy_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [RESP_BITS-1:0] response_q, response_d;
  logic [RESP_BITS-1:0] tie_mask_q, tie_mask_d;

  logic last_pair;
  assign last_pair = (pair_sel_q == SEL_W'(RESP_BITS - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CLEAR;
      S_CLEAR:   state_d = S_COUNT;
      S_COUNT:   if (timer_q == '0) state_d = S_SETTLE;
      S_SETTLE:  if (settle_q) state_d = S_COMPARE;
      S_COMPARE: state_d = last_pair ? S_DONE : S_CLEAR;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next values: window latch, countdown timer, pair index and result shadows
  always_comb begin
    win_m1_d   = win_m1_q;
    timer_d    = timer_q;
    settle_d   = settle_q;
    pair_sel_d = pair_sel_q;
    sh_resp_d  = sh_resp_q;
    sh_tie_d   = sh_tie_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          win_m1_d   = (window == '0) ? '0 : window - WIN_SIZE'(1);
          pair_sel_d = '0;
        end
      end
      S_CLEAR: timer_d = win_m1_q;
      S_COUNT: begin
        settle_d = 1'b0;
        if (timer_q != '0) timer_d = timer_q - WIN_SIZE'(1);
      end
      S_SETTLE: settle_d = ~settle_q;
      S_COMPARE: begin
        sh_resp_d[pair_sel_q] = (cnt_a > cnt_b);
        sh_tie_d[pair_sel_q]  = (cnt_a == cnt_b);
        if (!last_pair) pair_sel_d = pair_sel_q + SEL_W'(1);
      end
      S_DONE: pair_sel_d = '0;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_m1_q   <= '0;
      timer_q    <= '0;
      settle_q   <= 1'b0;
      pair_sel_q <= '0;
      sh_resp_q  <= '0;
      sh_tie_q   <= '0;
    end else begin
      win_m1_q   <= win_m1_d;
      timer_q    <= timer_d;
      settle_q   <= settle_d;
      pair_sel_q <= pair_sel_d;
      sh_resp_q  <= sh_resp_d;
      sh_tie_q   <= sh_tie_d;
    end
  end

  // Output decode from the upcoming state so every output is a flop aligned with that state
  always_comb begin
    cnt_clr_d    = (state_d == S_CLEAR);
    cnt_en_d     = (state_d == S_COUNT);
    busy_d       = (state_d != S_IDLE);
    resp_valid_d = (state_d == S_DONE);
    response_d   = response_q;
    tie_mask_d   = tie_mask_q;
    if (state_d == S_DONE) begin
      // shadow _d already holds the bit written by the final compare
      response_d = sh_resp_d;
      tie_mask_d = sh_tie_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_en_q     <= 1'b0;
      cnt_clr_q    <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      response_q   <= '0;
      tie_mask_q   <= '0;
    end else begin
      cnt_en_q     <= cnt_en_d;
      cnt_clr_q    <= cnt_clr_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      response_q   <= response_d;
      tie_mask_q   <= tie_mask_d;
    end
  end

  assign cnt_en     = cnt_en_q;
  assign cnt_clr    = cnt_clr_q;
  assign pair_sel   = pair_sel_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign response   = response_q;
  assign tie_mask   = tie_mask_q;

endmodule

// File: tb/tb_ro_pair_measure.sv
// Bench for ro_pair_measure with RESP_BITS=4; expected responses are queued at start and popped at resp_valid.
module tb_ro_pair_measure;
  localparam int R  = 4;
  localparam int CS = 32;
  localparam int WS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [WS-1:0] window;
  logic [CS-1:0] cnt_a, cnt_b;
  logic          cnt_en, cnt_clr, busy, resp_valid;
  logic [1:0]    pair_sel;
  logic [R-1:0]  response, tie_mask;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [R-1:0] resp;
    logic [R-1:0] tie;
  } exp_t;
  exp_t sb[$];

  logic [CS-1:0] tbl_a[R];
  logic [CS-1:0] tbl_b[R];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter-pair model: cleared by cnt_clr, loads the routed pair's final count while enabled
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (cnt_clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (cnt_en) begin
      cnt_a <= tbl_a[pair_sel];
      cnt_b <= tbl_b[pair_sel];
    end
  end

  ro_pair_measure #(.CNT_SIZE(CS), .WIN_SIZE(WS), .RESP_BITS(R)) dut (
    .clk(clk), .reset(reset), .start(start), .window(window),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .pair_sel(pair_sel), .busy(busy), .resp_valid(resp_valid),
    .response(response), .tie_mask(tie_mask)
  );

  task automatic load_basic_table();
    tbl_a[0] = 32'd100;        tbl_b[0] = 32'd90;
    tbl_a[1] = 32'd50;         tbl_b[1] = 32'd60;
    tbl_a[2] = 32'd7;          tbl_b[2] = 32'd7;
    tbl_a[3] = 32'hFFFF_FFFF;  tbl_b[3] = 32'd0;
  endtask

  // Runs one measurement for a bounded number of cycles and records what the DUT did.
  task automatic run_watch(input int w, input int restart_at,
                           output int first_valid, output int nvalid,
                           output int tmis, output int early,
                           output logic [R-1:0] got_resp, output logic [R-1:0] got_tie);
    int W, P, last, ph, k, exp_sel;
    logic exp_clr, exp_en, exp_busy, exp_valid;
    logic [R-1:0] old_resp;
    W = (w == 0) ? 1 : w;
    P = W + 4;
    last = R * P + 1;
    first_valid = -1; nvalid = 0; tmis = 0; early = 0;
    got_resp = 'x; got_tie = 'x;
    old_resp = response;
    @(negedge clk);
    window = WS'(w);
    start  = 1'b1;
    for (int n = 1; n <= last + 4; n++) begin
      @(negedge clk);
      start     = (n == restart_at);
      ph        = (n - 1) % P;
      k         = (n - 1) / P;
      exp_clr   = (n < last) && (ph == 0);
      exp_en    = (n < last) && (ph >= 1) && (ph <= W);
      exp_busy  = (n <= last);
      exp_valid = (n == last);
      exp_sel   = (n <= last) ? ((k > R - 1) ? R - 1 : k) : 0;
      if (cnt_clr !== exp_clr || cnt_en !== exp_en || busy !== exp_busy ||
          resp_valid !== exp_valid || pair_sel !== 2'(exp_sel))
        tmis++;
      if (resp_valid === 1'b1) begin
        nvalid++;
        if (first_valid < 0) begin
          first_valid = n;
          got_resp = response;
          got_tie  = tie_mask;
        end
      end
      if (first_valid < 0 && response !== old_resp) early++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int busy_hi;
    reset = 1'b0; start = 1'b1; window = 16'd5;
    repeat (3) @(negedge clk);
    checks++;
    if ({cnt_en, cnt_clr, pair_sel, busy, resp_valid, response, tie_mask} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=0",
               {cnt_en, cnt_clr, pair_sel, busy, resp_valid, response, tie_mask});
    end
    start = 1'b0;
    reset = 1'b1;
    busy_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_hi++;
    end
    checks++;
    if (busy_hi !== 0) begin
      failures++;
      $display("FAIL idle_busy busy_cycles=%0d required=0", busy_hi);
    end
  endtask

  task automatic check_run(input string nm, input int exp_lat, input int fv, input int nv,
                           input int tm, input int ea,
                           input logic [R-1:0] gr, input logic [R-1:0] gt);
    exp_t e;
    checks++;
    if (fv !== exp_lat) begin failures++; $display("FAIL %s_latency got=%0d required=%0d", nm, fv, exp_lat); end
    checks++;
    if (nv !== 1) begin failures++; $display("FAIL %s_valid_count got=%0d required=1", nm, nv); end
    checks++;
    if (tm !== 0) begin failures++; $display("FAIL %s_timing mismatching_cycles=%0d required=0", nm, tm); end
    checks++;
    if (ea !== 0) begin failures++; $display("FAIL %s_hold early_changes=%0d required=0", nm, ea); end
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_scoreboard empty queue", nm);
    end else begin
      e = sb.pop_front();
      checks++;
      if (gr !== e.resp) begin failures++; $display("FAIL %s_response got=%b required=%b", nm, gr, e.resp); end
      checks++;
      if (gt !== e.tie) begin failures++; $display("FAIL %s_tie_mask got=%b required=%b", nm, gt, e.tie); end
    end
  endtask

  task automatic test_basic();
    int fv, nv, tm, ea;
    logic [R-1:0] gr, gt;
    load_basic_table();
    sb.push_back('{resp: 4'b1001, tie: 4'b0100});
    run_watch(10, -1, fv, nv, tm, ea, gr, gt);
    check_run("basic", 57, fv, nv, tm, ea, gr, gt);
  endtask

  task automatic test_window_zero();
    int fv, nv, tm, ea;
    logic [R-1:0] gr, gt;
    tbl_a[0] = 32'd3; tbl_b[0] = 32'd4;
    tbl_a[1] = 32'd9; tbl_b[1] = 32'd9;
    tbl_a[2] = 32'd8; tbl_b[2] = 32'd1;
    tbl_a[3] = 32'd0; tbl_b[3] = 32'd1;
    sb.push_back('{resp: 4'b0100, tie: 4'b0010});
    run_watch(0, -1, fv, nv, tm, ea, gr, gt);
    check_run("win0", R * 5 + 1, fv, nv, tm, ea, gr, gt);
  endtask

  task automatic test_start_busy();
    int fv, nv, tm, ea;
    logic [R-1:0] gr, gt;
    load_basic_table();
    sb.push_back('{resp: 4'b1001, tie: 4'b0100});
    run_watch(10, 14 + 5, fv, nv, tm, ea, gr, gt);
    check_run("busy_start", 57, fv, nv, tm, ea, gr, gt);
  endtask

  task automatic test_hold_ties();
    int fv, nv, tm, ea;
    logic [R-1:0] gr, gt;
    for (int i = 0; i < R; i++) begin
      tbl_a[i] = 32'(i * 3 + 5);
      tbl_b[i] = 32'(i * 3 + 5);
    end
    sb.push_back('{resp: 4'b0000, tie: 4'b1111});
    run_watch(6, -1, fv, nv, tm, ea, gr, gt);
    check_run("ties", R * 10 + 1, fv, nv, tm, ea, gr, gt);
  endtask

  task automatic test_reset_mid();
    int fv, nv, tm, ea;
    logic [R-1:0] gr, gt;
    load_basic_table();
    @(negedge clk);
    window = 16'd10;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // cycle 1 sampled above; cycle 40 is the first settle cycle of pair 2
    repeat (39) @(negedge clk);
    checks++;
    if (pair_sel !== 2'd2 || busy !== 1'b1 || cnt_en !== 1'b0) begin
      failures++;
      $display("FAIL midrun_settle sel=%0d busy=%b en=%b required sel=2 busy=1 en=0", pair_sel, busy, cnt_en);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({cnt_en, cnt_clr, busy, pair_sel, resp_valid} !== '0) begin
      failures++;
      $display("FAIL midrun_async got=%b required=0", {cnt_en, cnt_clr, busy, pair_sel, resp_valid});
    end
    @(negedge clk);
    reset = 1'b1;
    sb.push_back('{resp: 4'b1001, tie: 4'b0100});
    run_watch(10, -1, fv, nv, tm, ea, gr, gt);
    check_run("after_reset", 57, fv, nv, tm, ea, gr, gt);
  endtask

  task automatic test_window_max();
    int en_cnt, budget;
    logic seen;
    en_cnt = 0; seen = 1'b0; budget = 0;
    @(negedge clk);
    window = 16'hFFFF;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (budget < 70000 && !(seen && cnt_en === 1'b0)) begin
      if (cnt_en === 1'b1) begin
        en_cnt++;
        seen = 1'b1;
      end
      @(negedge clk);
      budget++;
    end
    checks++;
    if (en_cnt !== 65535) begin
      failures++;
      $display("FAIL winmax_en_cycles got=%0d required=65535", en_cnt);
    end
    checks++;
    if (pair_sel !== 2'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL winmax_state sel=%0d busy=%b required sel=0 busy=1", pair_sel, busy);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    window = '0;
    test_reset();
    test_basic();
    test_window_zero();
    test_start_busy();
    test_hold_ties();
    test_reset_mid();
    test_window_max();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
